q_value_updater: RTL and testbench
==================================

Q_VALUE_UPDATER -- requirements
Module: q_value_updater

Interface
REQ-001 Parameter STATE_W, default 4: state index width (2^STATE_W table rows).
REQ-002 Parameter ALPHA, default 8'd26: learning rate, unsigned Q0.8.
REQ-003 Parameter GAMMA, default 8'd230: discount factor, unsigned Q0.8.
REQ-004 Ports SHALL be as follows.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- state  in  STATE_W  row index of current state s.
- next_state  in  STATE_W  row index of s'.
- action  in  4  taken action: 4 selects row[15:0], 3 selects [31:16], 2 selects [47:32], 1 selects [63:48].
- reward  in  16  signed Q8.8 reward.
- terminal  in  1  s' is terminal; max Q(s') is forced to 0.
- rd_en  out  1  table read strobe.
- rd_addr  out  STATE_W  table read row.
- rd_data  in  64  row data, valid one cycle after rd_en.
- wr_en  out  1  table write strobe.
- wr_addr  out  STATE_W  table write row.
- wr_data  out  64  full updated row.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when action was not in 1..4.

Function
REQ-005 Q values SHALL be unsigned Q8.8, 16 bits per lane.
REQ-006 On start in IDLE, state, next_state, action, reward and terminal SHALL be latched; input changes after that cycle SHALL have no effect.
REQ-007 FSM states SHALL be IDLE, RD_CUR, RD_NXT, CAP_NXT, CALC, WRITE, DONE, each advancing unconditionally after one cycle, except IDLE.
REQ-008 RD_CUR SHALL drive rd_en=1 and rd_addr=state; RD_NXT SHALL drive rd_en=1 and rd_addr=next_state, and capture the current row.
REQ-009 CAP_NXT SHALL capture the next row and register maxn, the unsigned maximum of its four lanes, or 0 if terminal.
REQ-010 CALC SHALL compute the update in signed 20-bit arithmetic.
- target = reward + ((GAMMA*maxn)>>8)
- delta = target - q_old
- q_new = q_old + ((ALPHA*delta)>>>8), arithmetic shift, floor rounding.
REQ-011 WRITE SHALL drive wr_en=1 and wr_addr=state for exactly one cycle, with wr_data equal to the captured row and only the selected lane replaced by q_new[15:0].
REQ-012 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-013 Timing relative to the start-sample edge: wr_en SHALL be asserted 5 cycles later and done 6 cycles later.
REQ-014 An invalid action (0 or greater than 4) SHALL skip wr_en and assert err=1 together with done.
REQ-015 start while busy SHALL be ignored and not queued.
REQ-016 state equal to next_state SHALL be legal; both reads are still issued.
REQ-017 rd_en, wr_en, done and err SHALL be 0 in all other states.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, clear all registers, and drive every output to 0, including mid-operation; no write SHALL complete.
REQ-019 After rst_n rises, the first start SHALL be accepted normally.

Configuration
REQ-020 With Q_UPDATER_SAT_EN defined, q_new SHALL saturate to the range 0x0000 to 0xFFFF.
REQ-021 Without Q_UPDATER_SAT_EN, q_new SHALL be truncated to its low 16 bits.

Structure
REQ-022 Package q_learning_pkg SHALL hold the FSM state enum, the Q-value and reward widths, the action encodings (1 to 4) and the lane-index mapping shared with the action selector.
REQ-023 Sub-module q_row_max SHALL be the combinational four-lane unsigned maximum, instantiated for maxn.

Verification
REQ-024 Directed scenarios: the bench SHALL use ALPHA=128 unless noted.
- GAMMA=128; current row lanes all 0x0100; action=4; reward=0x0200; next row max 0x0400 -> wr_data[15:0]=0x0280, other lanes 0x0100, wr_en at +5, done at +6.
- GAMMA=255; q_old=0xFF00; reward=0x7FFF; next max 0xFFFF -> 0xFFFF with macro, 0x3EFF without.
- terminal=1; q_old=0x0100; reward=0xFC00 -> 0x0000 with macro, 0xFE80 without.
- action=0 -> no wr_en, done=1 and err=1 at +6.
- rst_n pulsed low during CALC -> all outputs 0 immediately, no wr_en; next start completes normally.
- start held high throughout -> back-to-back operations 7 cycles apart; each shows exactly one rd_en pair and one wr_en.

Source files
------------

// File: rtl/q_learning_pkg.sv
// Shared types and constants for the Q-learning table updater:
// FSM state encoding, Q/reward/arithmetic widths, action codes and the
// action-to-lane mapping used by the lane selector.
`timescale 1ns/1ps
package q_learning_pkg;

    localparam int Q_W         = 16;              // unsigned Q8.8 Q value
    localparam int REWARD_W    = 16;              // signed Q8.8 reward
    localparam int CALC_W      = 20;              // signed update arithmetic width
    localparam int ALPHA_W     = 8;               // unsigned Q0.8 coefficients
    localparam int STEP_PROD_W = CALC_W + ALPHA_W + 1;
    localparam int NUM_LANES   = 4;
    localparam int ROW_W       = Q_W * NUM_LANES;
    localparam int ACTION_W    = 4;
    localparam int LANE_W      = 2;

    // Valid action codes; action 4 owns the lowest lane, action 1 the highest
    localparam logic [ACTION_W-1:0] ACTION_1 = 4'd1;
    localparam logic [ACTION_W-1:0] ACTION_2 = 4'd2;
    localparam logic [ACTION_W-1:0] ACTION_3 = 4'd3;
    localparam logic [ACTION_W-1:0] ACTION_4 = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_CUR  = 3'd1,
        S_RD_NXT  = 3'd2,
        S_CAP_NXT = 3'd3,
        S_CALC    = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } fsm_state_t;

    function automatic logic action_is_valid(input logic [ACTION_W-1:0] a);
        return (a >= ACTION_1) && (a <= ACTION_4);
    endfunction

    // Lane index inside a row: action 4 -> lane 0 ([15:0]) ... action 1 -> lane 3 ([63:48])
    function automatic logic [LANE_W-1:0] action_to_lane(input logic [ACTION_W-1:0] a);
        logic [ACTION_W-1:0] l;
        l = ACTION_4 - a;
        return l[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/q_row_max.sv
// Combinational unsigned maximum of the four Q lanes of one table row.
`timescale 1ns/1ps
module q_row_max
    import q_learning_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [Q_W-1:0]   o_max
);

    logic [Q_W-1:0] w_lane [NUM_LANES];
    logic [Q_W-1:0] w_max01;
    logic [Q_W-1:0] w_max23;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign w_lane[gi] = i_row[gi*Q_W +: Q_W];
        end
    endgenerate

    // Two-level compare tree
    assign w_max01 = (w_lane[0] > w_lane[1]) ? w_lane[0] : w_lane[1];
    assign w_max23 = (w_lane[2] > w_lane[3]) ? w_lane[2] : w_lane[3];
    assign o_max   = (w_max01 > w_max23) ? w_max01 : w_max23;

endmodule

// File: rtl/q_value_updater.sv
// Single-entry Q-learning update engine:
//   Q(s,a) += ALPHA * (r + GAMMA * max Q(s') - Q(s,a))
// Reads rows s and s' from an external table (one-cycle read latency),
// computes the new lane value and writes the full row back.
// Optional build macro Q_UPDATER_SAT_EN: clamp q_new to 0x0000..0xFFFF
// instead of keeping its low 16 bits.
`timescale 1ns/1ps
module q_value_updater
    import q_learning_pkg::*;
#(
    parameter int                 STATE_W = 4,
    parameter logic [ALPHA_W-1:0] ALPHA   = 8'd26,
    parameter logic [ALPHA_W-1:0] GAMMA   = 8'd230
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [STATE_W-1:0]    state,
    input  logic [STATE_W-1:0]    next_state,
    input  logic [ACTION_W-1:0]   action,
    input  logic [REWARD_W-1:0]   reward,
    input  logic                  terminal,
    output logic                  rd_en,
    output logic [STATE_W-1:0]    rd_addr,
    input  logic [ROW_W-1:0]      rd_data,
    output logic                  wr_en,
    output logic [STATE_W-1:0]    wr_addr,
    output logic [ROW_W-1:0]      wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    fsm_state_t             r_fsm;
    fsm_state_t             w_fsm_next;

    logic [STATE_W-1:0]     r_state;
    logic [STATE_W-1:0]     r_next_state;
    logic [LANE_W-1:0]      r_lane;
    logic                   r_act_ok;
    logic [REWARD_W-1:0]    r_reward;
    logic                   r_terminal;
    logic [ROW_W-1:0]       r_cur_row;
    logic [Q_W-1:0]         r_maxn;
    logic [Q_W-1:0]         r_q_new;

    logic [Q_W-1:0]         w_row_max;
    logic [Q_W-1:0]         w_cur_lane [NUM_LANES];
    logic [ROW_W-1:0]       w_upd_row;
    logic [Q_W-1:0]         w_q_old;
    logic [2*Q_W-1:0]       w_disc_prod;
    logic signed [CALC_W-1:0]      w_target;
    logic signed [CALC_W-1:0]      w_delta;
    logic signed [STEP_PROD_W-1:0] w_step_prod;
    logic signed [CALC_W-1:0]      w_step;
    logic signed [CALC_W-1:0]      w_q_calc;
    logic [Q_W-1:0]         w_q_final;

    // Maximum of the next-state row, taken straight off the read bus
    q_row_max u_next_max (
        .i_row (rd_data),
        .o_max (w_row_max)
    );

    // Split the captured row into lanes and build the write-back row
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign w_cur_lane[gi] = r_cur_row[gi*Q_W +: Q_W];
            assign w_upd_row[gi*Q_W +: Q_W] =
                (r_lane == LANE_W'(gi)) ? r_q_new : w_cur_lane[gi];
        end
    endgenerate

    // Update arithmetic; shifts floor toward minus infinity
    assign w_q_old     = w_cur_lane[r_lane];
    assign w_disc_prod = (2*Q_W)'(GAMMA) * (2*Q_W)'(r_maxn);
    assign w_target    = {{(CALC_W-REWARD_W){r_reward[REWARD_W-1]}}, r_reward}
                       + CALC_W'(w_disc_prod >> 8);
    assign w_delta     = w_target - {{(CALC_W-Q_W){1'b0}}, w_q_old};
    assign w_step_prod = $signed({{(STEP_PROD_W-CALC_W){w_delta[CALC_W-1]}}, w_delta})
                       * $signed({{(STEP_PROD_W-ALPHA_W){1'b0}}, ALPHA});
    assign w_step      = CALC_W'(w_step_prod >>> 8);
    assign w_q_calc    = {{(CALC_W-Q_W){1'b0}}, w_q_old} + w_step;

`ifdef Q_UPDATER_SAT_EN
    // Clamp negative results to 0 and overflow to full scale
    always_comb begin
        w_q_final = w_q_calc[Q_W-1:0];
        if (w_q_calc[CALC_W-1]) begin
            w_q_final = '0;
        end else if (|w_q_calc[CALC_W-2:Q_W]) begin
            w_q_final = '1;
        end
    end
`else
    assign w_q_final = Q_W'(w_q_calc);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state and Moore outputs; only IDLE waits, all others step once
    always_comb begin
        w_fsm_next = r_fsm;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (r_fsm != S_IDLE);
        case (r_fsm)
            S_IDLE:    if (start) w_fsm_next = S_RD_CUR;
            S_RD_CUR: begin
                w_fsm_next = S_RD_NXT;
                rd_en      = 1'b1;
                rd_addr    = r_state;
            end
            S_RD_NXT: begin
                w_fsm_next = S_CAP_NXT;
                rd_en      = 1'b1;
                rd_addr    = r_next_state;
            end
            S_CAP_NXT: w_fsm_next = S_CALC;
            S_CALC:    w_fsm_next = S_WRITE;
            S_WRITE: begin
                w_fsm_next = S_DONE;
                if (r_act_ok) begin
                    wr_en   = 1'b1;
                    wr_addr = r_state;
                    wr_data = w_upd_row;
                end
            end
            S_DONE: begin
                w_fsm_next = S_IDLE;
                done       = 1'b1;
                err        = ~r_act_ok;
            end
            default:   w_fsm_next = S_IDLE;
        endcase
    end

    // Request latch and datapath capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= '0;
            r_next_state <= '0;
            r_lane       <= '0;
            r_act_ok     <= 1'b0;
            r_reward     <= '0;
            r_terminal   <= 1'b0;
            r_cur_row    <= '0;
            r_maxn       <= '0;
            r_q_new      <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= state;
                        r_next_state <= next_state;
                        r_lane       <= action_to_lane(action);
                        r_act_ok     <= action_is_valid(action);
                        r_reward     <= reward;
                        r_terminal   <= terminal;
                    end
                end
                S_RD_NXT:  r_cur_row <= rd_data;
                S_CAP_NXT: r_maxn    <= r_terminal ? '0 : w_row_max;
                S_CALC:    r_q_new   <= w_q_final;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q_value_updater.sv
// Directed bench for q_value_updater with a behavioural one-cycle-latency table.
`timescale 1ns/1ps
module tb_q_value_updater;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [3:0]  state, next_state, action;
    logic [15:0] reward;
    logic        terminal;

    logic        rd_en_a, wr_en_a, busy_a, done_a, err_a;
    logic [3:0]  rd_addr_a, wr_addr_a;
    logic [63:0] rd_data_a, wr_data_a;
    logic        rd_en_b, wr_en_b, busy_b, done_b, err_b;
    logic [3:0]  rd_addr_b, wr_addr_b;
    logic [63:0] rd_data_b, wr_data_b;

    logic [63:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          wr_k;
        int          done_k;
        int          rd_cnt;
        int          wr_cnt;
        int          busy_cnt;
        logic [63:0] wdata;
        logic [3:0]  waddr;
        logic [3:0]  rd_a1;
        logic [3:0]  rd_a2;
        logic        err_v;
    } op_res_t;

    always #5 clk = ~clk;

    q_value_updater #(.STATE_W(4), .ALPHA(8'd128), .GAMMA(8'd128)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .state(state), .next_state(next_state),
        .action(action), .reward(reward), .terminal(terminal),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    q_value_updater #(.STATE_W(4), .ALPHA(8'd128), .GAMMA(8'd255)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .state(state), .next_state(next_state),
        .action(action), .reward(reward), .terminal(terminal),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Table model: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request; samples at negedges, k = edges after the start-sample edge
    task automatic run_op(input bit use_b, input logic [3:0] st, input logic [3:0] ns,
                          input logic [3:0] act, input logic [15:0] rew, input logic term,
                          output op_res_t r);
        r = '{wr_k: -1, done_k: -1, rd_cnt: 0, wr_cnt: 0, busy_cnt: 0,
              wdata: 64'd0, waddr: 4'd0, rd_a1: 4'd0, rd_a2: 4'd0, err_v: 1'b0};
        @(negedge clk);
        state = st; next_state = ns; action = act; reward = rew; terminal = term;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_a = 1'b0; start_b = 1'b0;
                state = ~st; next_state = ~ns; action = ~act; reward = ~rew; terminal = ~term;
            end
            if (k == 3) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            if (k == 4) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (use_b ? rd_en_b : rd_en_a) begin
                r.rd_cnt++;
                if (r.rd_cnt == 1) r.rd_a1 = use_b ? rd_addr_b : rd_addr_a;
                else               r.rd_a2 = use_b ? rd_addr_b : rd_addr_a;
            end
            if (use_b ? wr_en_b : wr_en_a) begin
                r.wr_cnt++;
                r.wr_k  = k;
                r.wdata = use_b ? wr_data_b : wr_data_a;
                r.waddr = use_b ? wr_addr_b : wr_addr_a;
            end
            if (use_b ? done_b : done_a) begin
                r.done_k = k;
                r.err_v  = use_b ? err_b : err_a;
            end
            if (use_b ? busy_b : busy_a) r.busy_cnt++;
        end
    endtask

    task automatic check_op(input string tag, input op_res_t r, input bit exp_err,
                            input logic [3:0] st, input logic [3:0] ns, input logic [63:0] exp_row);
        chk({tag, ".rd_cnt"},   64'(r.rd_cnt), 64'd2);
        chk({tag, ".rd_addr1"}, 64'(r.rd_a1), 64'(st));
        chk({tag, ".rd_addr2"}, 64'(r.rd_a2), 64'(ns));
        chk({tag, ".done_k"},   64'(r.done_k), 64'd6);
        chk({tag, ".err"},      64'(r.err_v), 64'(exp_err));
        chk({tag, ".busy_cnt"}, 64'(r.busy_cnt), 64'd6);
        if (exp_err) begin
            chk({tag, ".wr_cnt"}, 64'(r.wr_cnt), 64'd0);
        end else begin
            chk({tag, ".wr_cnt"},  64'(r.wr_cnt), 64'd1);
            chk({tag, ".wr_k"},    64'(r.wr_k), 64'd5);
            chk({tag, ".wr_addr"}, 64'(r.waddr), 64'(st));
            chk({tag, ".wr_data"}, r.wdata, exp_row);
        end
    endtask

    logic [15:0] exp_sat_hi, exp_sat_lo;
    op_res_t     res;
    int          rd_cnt, wr_cnt, n_done;
    int          done_at [3];
    int          wr_at [3];

    initial begin
`ifdef Q_UPDATER_SAT_EN
        exp_sat_hi = 16'hFFFF;
        exp_sat_lo = 16'h0000;
`else
        exp_sat_hi = 16'h3EFF;
        exp_sat_lo = 16'hFE80;
`endif
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        state = '0; next_state = '0; action = '0; reward = '0; terminal = 1'b0;
        rd_data_a = '0; rd_data_b = '0;
        for (int i = 0; i < 16; i++) mem[i] = {4{16'h5A5A}};
        mem[2] = {4{16'h0100}};
        mem[5] = {16'h0400, 16'h0010, 16'h0300, 16'h0001};
        mem[7] = {16'h1111, 16'h2222, 16'hFF00, 16'h3333};
        mem[8] = {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        mem[9] = {16'h0100, 16'hAAAA, 16'hBBBB, 16'hCCCC};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.ctrl_a", {59'd0, rd_en_a, wr_en_a, busy_a, done_a, err_a}, 64'd0);
        chk("reset.addr_a", {56'd0, rd_addr_a, wr_addr_a}, 64'd0);
        chk("reset.wdata_a", wr_data_a, 64'd0);
        chk("reset.ctrl_b", {59'd0, rd_en_b, wr_en_b, busy_b, done_b, err_b}, 64'd0);
        rst_n = 1'b1;

        // Basic update, GAMMA=128: 0x0100 -> 0x0280 in lane 0
        run_op(1'b0, 4'd2, 4'd5, 4'd4, 16'h0200, 1'b0, res);
        check_op("basic", res, 1'b0, 4'd2, 4'd5, {16'h0100, 16'h0100, 16'h0100, 16'h0280});

        // Overflow case, GAMMA=255, action 3 -> lane [31:16]
        run_op(1'b1, 4'd7, 4'd8, 4'd3, 16'h7FFF, 1'b0, res);
        check_op("overflow", res, 1'b0, 4'd7, 4'd8, {16'h1111, 16'h2222, exp_sat_hi, 16'h3333});

        // Terminal next state, negative reward, s == s', action 1 -> lane [63:48]
        run_op(1'b0, 4'd9, 4'd9, 4'd1, 16'hFC00, 1'b1, res);
        check_op("terminal", res, 1'b0, 4'd9, 4'd9, {exp_sat_lo, 16'hAAAA, 16'hBBBB, 16'hCCCC});

        // Invalid actions
        run_op(1'b0, 4'd2, 4'd5, 4'd0, 16'h0200, 1'b0, res);
        check_op("act0", res, 1'b1, 4'd2, 4'd5, 64'd0);
        run_op(1'b0, 4'd2, 4'd5, 4'd5, 16'h0200, 1'b0, res);
        check_op("act5", res, 1'b1, 4'd2, 4'd5, 64'd0);

        // Reset asserted during CALC
        @(negedge clk);
        state = 4'd2; next_state = 4'd5; action = 4'd4; reward = 16'h0200; terminal = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.in_calc", 64'(busy_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ctrl", {59'd0, rd_en_a, wr_en_a, busy_a, done_a, err_a}, 64'd0);
        chk("rst_mid.addr", {56'd0, rd_addr_a, wr_addr_a}, 64'd0);
        chk("rst_mid.wdata", wr_data_a, 64'd0);
        wr_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wr_en_a || done_a) wr_cnt++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (wr_en_a || done_a) wr_cnt++;
        end
        chk("rst_mid.no_write", 64'(wr_cnt), 64'd0);
        run_op(1'b0, 4'd2, 4'd5, 4'd4, 16'h0200, 1'b0, res);
        check_op("after_rst", res, 1'b0, 4'd2, 4'd5, {16'h0100, 16'h0100, 16'h0100, 16'h0280});

        // start held high: operations every 7 cycles
        @(negedge clk);
        state = 4'd2; next_state = 4'd5; action = 4'd4; reward = 16'h0200; terminal = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        rd_cnt = 0; wr_cnt = 0; n_done = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (rd_en_a) rd_cnt++;
            if (wr_en_a) begin
                if (wr_cnt < 3) wr_at[wr_cnt] = k;
                wr_cnt++;
                chk("b2b.wr_data", wr_data_a, {16'h0100, 16'h0100, 16'h0100, 16'h0280});
            end
            if (done_a) begin
                if (n_done < 3) done_at[n_done] = k;
                n_done++;
            end
            if (k == 21) start_a = 1'b0;
        end
        chk("b2b.rd_cnt", 64'(rd_cnt), 64'd6);
        chk("b2b.wr_cnt", 64'(wr_cnt), 64'd3);
        chk("b2b.done_cnt", 64'(n_done), 64'd3);
        if (wr_cnt == 3 && n_done == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b2b.wr_at%0d", i), 64'(wr_at[i]), 64'(5 + 7*i));
                chk($sformatf("b2b.done_at%0d", i), 64'(done_at[i]), 64'(6 + 7*i));
            end
        end
        repeat (8) @(negedge clk);
        chk("b2b.idle", 64'(busy_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
